// File: rtl/lazy_seq_collector.sv
// Lazy match sequence collector: tracks the per-job head pointer, keeps one lazy
// summary in flight, carries match overlap across jobs and queues sequences for the encoder.
module lazy_seq_collector #(
  parameter int JOB_LEN_LOG2    = 6,
  parameter int SEQ_LL_BITS     = 8,
  parameter int SEQ_ML_BITS     = 8,
  parameter int SEQ_OFFSET_BITS = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_job_valid,
  input  logic                       i_job_delim,
  output logic                       o_job_ready,
  output logic                       o_head_valid,
  output logic [JOB_LEN_LOG2-1:0]    o_seq_head_ptr,
  output logic                       o_delim,
  input  logic                       i_issue,
  input  logic                       i_summary_done,
  input  logic [JOB_LEN_LOG2-1:0]    i_seq_head_ptr,
  input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
  input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
  input  logic                       i_summary_eoj,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
  input  logic                       i_move_to_next_job,
  input  logic [JOB_LEN_LOG2-1:0]    i_move_forward,
  output logic                       o_seq_valid,
  input  logic                       i_seq_ready,
  output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
  output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
  output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
  output logic                       o_seq_eoj,
  output logic                       o_seq_delim,
  output logic                       o_error
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = SEQ_LL_BITS + SEQ_ML_BITS + SEQ_OFFSET_BITS + 2;
  localparam logic [SEQ_ML_BITS:0]   C_JOB_LEN    = (SEQ_ML_BITS+1)'(1 << JOB_LEN_LOG2);
  localparam logic [SEQ_ML_BITS-1:0] C_JOB_LEN_LO = C_JOB_LEN[SEQ_ML_BITS-1:0];
  localparam logic [CNT_W-1:0]       C_DEPTH      = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_WAIT} state_t;

  state_t                  r_state;
  logic [JOB_LEN_LOG2-1:0] r_head;
  logic [SEQ_ML_BITS-1:0]  r_carry;
  logic                    r_delim;
  logic                    r_head_valid;
  logic                    r_error;
  logic [ENTRY_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  logic               w_full;
  logic               w_job_fire;
  logic               w_carry_cover;
  logic               w_sum_fire;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_push_data;
  logic [CNT_W-1:0]   w_count_next;
  logic               w_to_ready;
  logic               w_err;

  assign w_full        = (r_count == C_DEPTH);
  assign w_job_fire    = (r_state == S_IDLE) && i_job_valid && !w_full;
  assign w_carry_cover = ({1'b0, r_carry} >= C_JOB_LEN);
  assign w_sum_fire    = (r_state == S_WAIT) && i_summary_done;
  assign w_push        = w_sum_fire || (w_job_fire && w_carry_cover && i_job_delim);
  assign w_pop         = (r_count != '0) && i_seq_ready;

  // A job swallowed by the previous match only emits a marker when it closes the block.
  assign w_push_data = w_sum_fire
    ? {i_summary_ll, i_summary_ml, i_summary_offset, i_summary_eoj, r_delim & i_summary_eoj}
    : {{(ENTRY_W-2){1'b0}}, 2'b11};

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CNT_W'(1);
    else if (w_pop && !w_push)
      w_count_next = r_count - CNT_W'(1);
  end

  assign w_to_ready = (w_job_fire && !w_carry_cover)
                   || ((r_state == S_READY) && !(i_issue && r_head_valid))
                   || (w_sum_fire && !i_move_to_next_job);

  assign w_err = ((r_state == S_READY) && i_issue && !r_head_valid)
              || (i_summary_done && (r_state != S_WAIT))
              || (w_sum_fire && (i_seq_head_ptr != r_head));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_head       <= '0;
      r_carry      <= '0;
      r_delim      <= 1'b0;
      r_head_valid <= 1'b0;
      r_error      <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // One slot stays reserved for the summary that an issue will bring back.
      r_head_valid <= w_to_ready && (w_count_next < C_DEPTH);
      if (w_err) r_error <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_job_fire) begin
            if (w_carry_cover) begin
              r_carry <= i_job_delim ? '0 : (r_carry - C_JOB_LEN_LO);
            end else begin
              r_head  <= r_carry[JOB_LEN_LOG2-1:0];
              r_delim <= i_job_delim;
              r_state <= S_READY;
            end
          end
        end
        S_READY: begin
          if (i_issue && r_head_valid) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_summary_done) begin
            if (i_move_to_next_job) begin
              r_carry <= r_delim ? '0 : i_summary_overlap_len;
              r_state <= S_IDLE;
            end else begin
              r_head  <= r_head + i_move_forward;
              r_state <= S_READY;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign o_job_ready    = (r_state == S_IDLE) && !w_full;
  assign o_head_valid   = r_head_valid;
  assign o_seq_head_ptr = r_head;
  assign o_delim        = r_delim;
  assign o_seq_valid    = (r_count != '0);
  assign o_error        = r_error;
  assign {o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim} = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_lazy_seq_collector.sv
// Bench for lazy_seq_collector: directed scenarios followed by a randomized run
// compared against a job/summary level reference model.
module tb_lazy_seq_collector;
  localparam int JL2 = 6;
  localparam int LLB = 8;
  localparam int MLB = 8;
  localparam int OFB = 16;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_job_valid, i_job_delim, o_job_ready, o_head_valid, o_delim;
  logic [JL2-1:0] o_seq_head_ptr, i_seq_head_ptr, i_move_forward;
  logic i_issue, i_summary_done, i_summary_eoj, i_move_to_next_job;
  logic [LLB-1:0] i_summary_ll, o_seq_ll;
  logic [MLB-1:0] i_summary_ml, i_summary_overlap_len, o_seq_ml;
  logic [OFB-1:0] i_summary_offset, o_seq_offset;
  logic o_seq_valid, i_seq_ready, o_seq_eoj, o_seq_delim, o_error;

  int n_tests = 0;
  int n_fail  = 0;

  lazy_seq_collector #(.JOB_LEN_LOG2(JL2), .SEQ_LL_BITS(LLB), .SEQ_ML_BITS(MLB),
                       .SEQ_OFFSET_BITS(OFB), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .i_job_valid(i_job_valid), .i_job_delim(i_job_delim), .o_job_ready(o_job_ready),
    .o_head_valid(o_head_valid), .o_seq_head_ptr(o_seq_head_ptr), .o_delim(o_delim),
    .i_issue(i_issue), .i_summary_done(i_summary_done), .i_seq_head_ptr(i_seq_head_ptr),
    .i_summary_ll(i_summary_ll), .i_summary_ml(i_summary_ml), .i_summary_offset(i_summary_offset),
    .i_summary_eoj(i_summary_eoj), .i_summary_overlap_len(i_summary_overlap_len),
    .i_move_to_next_job(i_move_to_next_job), .i_move_forward(i_move_forward),
    .o_seq_valid(o_seq_valid), .i_seq_ready(i_seq_ready), .o_seq_ll(o_seq_ll),
    .o_seq_ml(o_seq_ml), .o_seq_offset(o_seq_offset), .o_seq_eoj(o_seq_eoj),
    .o_seq_delim(o_seq_delim), .o_error(o_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_job_valid = 0; i_job_delim = 0; i_issue = 0; i_summary_done = 0;
    i_seq_head_ptr = '0; i_summary_ll = '0; i_summary_ml = '0; i_summary_offset = '0;
    i_summary_eoj = 0; i_summary_overlap_len = '0; i_move_to_next_job = 0;
    i_move_forward = '0; i_seq_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic send_job(input logic delim);
    i_job_valid = 1; i_job_delim = delim;
    step();
    i_job_valid = 0; i_job_delim = 0;
  endtask

  task automatic issue_one();
    i_issue = 1;
    step();
    i_issue = 0;
  endtask

  task automatic send_summary(input int ptr, input int ll, input int ml, input int off,
                              input logic eoj, input int ovl, input logic mtn, input int mf);
    i_summary_done = 1; i_seq_head_ptr = JL2'(ptr); i_summary_ll = LLB'(ll);
    i_summary_ml = MLB'(ml); i_summary_offset = OFB'(off); i_summary_eoj = eoj;
    i_summary_overlap_len = MLB'(ovl); i_move_to_next_job = mtn; i_move_forward = JL2'(mf);
    step();
    i_summary_done = 0; i_move_to_next_job = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (o_job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b want 1", o_job_ready); end
    n_tests++; if (o_head_valid !== 1'b0) begin n_fail++; $display("FAIL reset_head_valid: got %b want 0", o_head_valid); end
    n_tests++; if (o_seq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_seq_valid: got %b want 0", o_seq_valid); end
    n_tests++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", o_error); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    send_job(0);
    issue_one();
    #3 rst = 1;
    #1 rst = 0;
    i_summary_done = 1;
    step();
    i_summary_done = 0;
    n_tests++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL midwait_error: got %b want 1", o_error); end
    n_tests++; if (o_seq_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_seq_valid: got %b want 0", o_seq_valid); end
    n_tests++; if (o_job_ready !== 1'b1) begin n_fail++; $display("FAIL midwait_job_ready: got %b want 1", o_job_ready); end
    n_tests++; if (o_head_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_head_valid: got %b want 0", o_head_valid); end
    $display("[TB] test_reset_mid_wait done");
  endtask

  task automatic test_basic();
    do_reset();
    send_job(0);
    n_tests++; if (o_head_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hv_after_job: got %b want 1", o_head_valid); end
    n_tests++; if (o_seq_head_ptr !== 6'd0) begin n_fail++; $display("FAIL basic_head0: got %0d want 0", o_seq_head_ptr); end
    issue_one();
    n_tests++; if (o_head_valid !== 1'b0) begin n_fail++; $display("FAIL basic_hv_after_issue: got %b want 0", o_head_valid); end
    send_summary(0, 3, 10, 16'h1234, 0, 0, 0, 13);
    n_tests++; if (o_seq_valid !== 1'b1) begin n_fail++; $display("FAIL basic_seq_valid: got %b want 1", o_seq_valid); end
    n_tests++; if ({o_seq_ll, o_seq_ml, o_seq_offset} !== {8'd3, 8'd10, 16'h1234}) begin
      n_fail++; $display("FAIL basic_entry: got ll=%0d ml=%0d off=%h want 3 10 1234", o_seq_ll, o_seq_ml, o_seq_offset); end
    n_tests++; if (o_seq_head_ptr !== 6'd13) begin n_fail++; $display("FAIL basic_head13: got %0d want 13", o_seq_head_ptr); end
    n_tests++; if (o_head_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hv_after_done: got %b want 1", o_head_valid); end
    step();
    n_tests++; if (o_seq_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped: got %b want 0", o_seq_valid); end
    $display("[TB] test_basic done");
  endtask

  task automatic test_carry();
    issue_one();
    send_summary(13, 5, 70, 2, 1, 70, 1, 0);
    n_tests++; if (o_job_ready !== 1'b1) begin n_fail++; $display("FAIL carry_idle_ready: got %b want 1", o_job_ready); end
    n_tests++; if ({o_seq_eoj, o_seq_delim} !== 2'b10) begin n_fail++; $display("FAIL carry_eoj_delim: got %b%b want 10", o_seq_eoj, o_seq_delim); end
    step();
    send_job(0);
    n_tests++; if (o_head_valid !== 1'b0) begin n_fail++; $display("FAIL carry_covered_hv: got %b want 0", o_head_valid); end
    n_tests++; if (o_job_ready !== 1'b1) begin n_fail++; $display("FAIL carry_covered_ready: got %b want 1", o_job_ready); end
    send_job(0);
    n_tests++; if (o_head_valid !== 1'b1) begin n_fail++; $display("FAIL carry_next_hv: got %b want 1", o_head_valid); end
    n_tests++; if (o_seq_head_ptr !== 6'd6) begin n_fail++; $display("FAIL carry_head6: got %0d want 6", o_seq_head_ptr); end
    issue_one();
    send_summary(6, 1, 90, 3, 1, 80, 1, 0);
    step();
    $display("[TB] test_carry done");
  endtask

  task automatic test_delim_cover();
    send_job(1);
    n_tests++; if ({o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim} !== {1'b1, 34'b11}) begin
      n_fail++; $display("FAIL cover_entry: got v=%b ll=%0d ml=%0d off=%0d eoj=%b delim=%b want 1 0 0 0 1 1",
                         o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim); end
    n_tests++; if (o_head_valid !== 1'b0) begin n_fail++; $display("FAIL cover_hv: got %b want 0", o_head_valid); end
    step();
    send_job(0);
    n_tests++; if (o_seq_head_ptr !== 6'd0) begin n_fail++; $display("FAIL cover_carry_cleared: got head %0d want 0", o_seq_head_ptr); end
    n_tests++; if (o_head_valid !== 1'b1) begin n_fail++; $display("FAIL cover_next_hv: got %b want 1", o_head_valid); end
    $display("[TB] test_delim_cover done");
  endtask

  task automatic test_back_to_back();
    i_seq_ready = 0;
    for (int k = 0; k < 4; k++) begin
      issue_one();
      send_summary(3 * k, k + 1, k + 20, k, 0, 0, 0, 3);
      if (k == 2) begin
        n_tests++; if (o_head_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hv_three: got %b want 1", o_head_valid); end
      end
    end
    n_tests++; if (o_head_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hv_full: got %b want 0", o_head_valid); end
    i_issue = 1;
    step();
    step();
    i_issue = 0;
    n_tests++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL bp_issue_error: got %b want 1", o_error); end
    n_tests++; if (o_head_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hv_hold: got %b want 0", o_head_valid); end
    i_seq_ready = 1;
    for (int k = 0; k < 4; k++) begin
      n_tests++; if ({o_seq_valid, o_seq_ll, o_seq_ml} !== {1'b1, 8'(k + 1), 8'(k + 20)}) begin
        n_fail++; $display("FAIL bp_drain_%0d: got v=%b ll=%0d ml=%0d want 1 %0d %0d", k, o_seq_valid, o_seq_ll, o_seq_ml, k + 1, k + 20); end
      step();
    end
    n_tests++; if (o_seq_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", o_seq_valid); end
    n_tests++; if (o_seq_head_ptr !== 6'd12) begin n_fail++; $display("FAIL bp_head: got %0d want 12", o_seq_head_ptr); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_mismatch();
    do_reset();
    send_job(0);
    issue_one();
    send_summary(0, 1, 4, 0, 0, 0, 0, 7);
    issue_one();
    n_tests++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL mm_no_error_yet: got %b want 0", o_error); end
    send_summary(5, 9, 11, 0, 0, 0, 0, 1);
    n_tests++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL mm_error: got %b want 1", o_error); end
    n_tests++; if ({o_seq_valid, o_seq_ll, o_seq_ml} !== {1'b1, 8'd9, 8'd11}) begin
      n_fail++; $display("FAIL mm_entry: got v=%b ll=%0d ml=%0d want 1 9 11", o_seq_valid, o_seq_ll, o_seq_ml); end
    $display("[TB] test_mismatch done");
  endtask

  task automatic test_random();
    logic [33:0] exp_q[$];
    logic [33:0] got;
    int  phase;   // 0: between jobs, 1: head presented, 2: evaluation outstanding
    int  m_head, m_carry;
    bit  m_delim, do_pop;
    do_reset();
    phase = 0; m_head = 0; m_carry = 0; m_delim = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_job_valid = 0; i_issue = 0; i_summary_done = 0; i_move_to_next_job = 0;
      i_seq_ready = ($urandom_range(0, 2) != 0);
      if (phase == 0) begin
        i_job_valid = $urandom_range(0, 1);
        i_job_delim = ($urandom_range(0, 3) == 0);
      end else if (phase == 1 && exp_q.size() < DEP) begin
        i_issue = $urandom_range(0, 1);
      end else if (phase == 2 && $urandom_range(0, 2) == 0) begin
        i_summary_done = 1;
        i_seq_head_ptr = JL2'(m_head);
        i_summary_ll = LLB'($urandom); i_summary_ml = MLB'($urandom);
        i_summary_offset = OFB'($urandom); i_summary_eoj = $urandom_range(0, 1);
        i_summary_overlap_len = MLB'($urandom_range(0, 200));
        i_move_to_next_job = ($urandom_range(0, 2) == 0);
        i_move_forward = JL2'($urandom);
      end
      n_tests++; if (o_job_ready !== (phase == 0 && exp_q.size() < DEP)) begin
        n_fail++; $display("FAIL rnd_job_ready cyc %0d: got %b", cyc, o_job_ready); end
      n_tests++; if (o_head_valid !== (phase == 1 && exp_q.size() < DEP)) begin
        n_fail++; $display("FAIL rnd_head_valid cyc %0d: got %b", cyc, o_head_valid); end
      if (phase == 1) begin
        n_tests++; if (o_seq_head_ptr !== JL2'(m_head)) begin
          n_fail++; $display("FAIL rnd_head cyc %0d: got %0d want %0d", cyc, o_seq_head_ptr, m_head); end
      end
      n_tests++; if (o_seq_valid !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_seq_valid cyc %0d: got %b want %b", cyc, o_seq_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        got = {o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim};
        n_tests++; if (got !== exp_q[0]) begin
          n_fail++; $display("FAIL rnd_entry cyc %0d: got %h want %h", cyc, got, exp_q[0]); end
      end
      n_tests++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL rnd_error cyc %0d: got %b want 0", cyc, o_error); end

      do_pop = (exp_q.size() != 0) && i_seq_ready;
      if (phase == 0 && i_job_valid && exp_q.size() < DEP) begin
        if (m_carry < (1 << JL2)) begin
          m_head = m_carry % (1 << JL2); m_delim = i_job_delim; phase = 1;
        end else begin
          m_carry = m_carry - (1 << JL2);
          if (i_job_delim) begin
            exp_q.push_back(34'b11);
            m_carry = 0;
          end
        end
      end else if (phase == 1 && i_issue) begin
        phase = 2;
      end else if (phase == 2 && i_summary_done) begin
        exp_q.push_back({i_summary_ll, i_summary_ml, i_summary_offset, i_summary_eoj,
                         m_delim & i_summary_eoj});
        if (i_move_to_next_job) begin
          m_carry = m_delim ? 0 : int'(i_summary_overlap_len);
          phase = 0;
        end else begin
          m_head = (m_head + int'(i_move_forward)) % (1 << JL2);
          phase = 1;
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      step();
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_reset_mid_wait();
    test_basic();
    test_carry();
    test_delim_cover();
    test_back_to_back();
    test_mismatch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
